// File: rtl/plt_land_if.sv
// Interface between the character physics, the platform table and plt_land_unit.
// master: physics / platform-table side; it drives the frame request, character position and the
//         packed platform slots, and receives the landing results.
// slave:  plt_land_unit; it receives the request and slot table, and drives busy/done and results.
// Slot i of plt_x/plt_y/plt_w sits at bits [i*POS_W +: POS_W]; plt_x/plt_y are signed and
// plt_w is unsigned.
interface plt_land_if #(
  parameter int unsigned NUM_PLT = 4,
  parameter int unsigned POS_W   = 11
);
  localparam int unsigned IdxW = (NUM_PLT > 1) ? $clog2(NUM_PLT) : 1;

  logic                     frame_tick;
  logic [POS_W-1:0]         x_pos;
  logic [POS_W-1:0]         y_pos;
  logic [POS_W-1:0]         next_y;
  logic                     drop_req;
  logic [NUM_PLT-1:0]       plt_en;
  logic [NUM_PLT*POS_W-1:0] plt_x;
  logic [NUM_PLT*POS_W-1:0] plt_y;
  logic [NUM_PLT*POS_W-1:0] plt_w;
  logic                     busy;
  logic                     done;
  logic                     grounded;
  logic [IdxW-1:0]          plt_idx;
  logic [POS_W-1:0]         snap_y;
  logic                     land_pulse;
  logic                     dropping;

  modport master (
    output frame_tick, x_pos, y_pos, next_y, drop_req, plt_en, plt_x, plt_y, plt_w,
    input  busy, done, grounded, plt_idx, snap_y, land_pulse, dropping
  );

  modport slave (
    input  frame_tick, x_pos, y_pos, next_y, drop_req, plt_en, plt_x, plt_y, plt_w,
    output busy, done, grounded, plt_idx, snap_y, land_pulse, dropping
  );
endinterface

// File: rtl/plt_land_unit.sv
// Multi-platform landing detector.
// On each accepted frame_tick it latches the character position and scans the NUM_PLT platform
// slots, one per clock. It picks the highest platform that supports the character and commits
// the grounded state, the supporting slot index and the snapped top edge. It also handles a
// timed drop-through of the platform the character is standing on.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  plt_land_if.slave: frame_tick/position/drop_req/slot table in;
//        busy, done, grounded, plt_idx, snap_y, land_pulse and dropping out.
module plt_land_unit #(
  parameter int unsigned NUM_PLT     = 4,
  parameter int unsigned POS_W       = 11,
  parameter int unsigned WIDTH       = 23,
  parameter int unsigned HEIGHT      = 30,
  parameter int unsigned SCALE       = 2,
  parameter int unsigned DROP_FRAMES = 12
) (
  input logic       clk,
  input logic       rst,
  plt_land_if.slave bus
);
  localparam int unsigned IdxW = (NUM_PLT > 1) ? $clog2(NUM_PLT) : 1;
  // Three guard bits keep x + w (w unsigned, up to 2^POS_W - 1) and y + footprint exact.
  localparam int unsigned ExtW = POS_W + 3;
  localparam int unsigned CntW = (DROP_FRAMES > 0) ? $clog2(DROP_FRAMES + 1) : 1;
  localparam logic signed [ExtW-1:0] FootW = ExtW'(WIDTH * SCALE);
  localparam logic signed [ExtW-1:0] FootH = ExtW'(HEIGHT * SCALE);

  function automatic logic signed [ExtW-1:0] sext(input logic [POS_W-1:0] v);
    return {{3{v[POS_W-1]}}, v};
  endfunction

  function automatic logic signed [ExtW-1:0] zext(input logic [POS_W-1:0] v);
    return {3'b000, v};
  endfunction

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e state_q, state_d;
  logic   start, scan, commit, last;

  logic signed [ExtW-1:0] x_q, x_d, y_q, y_d, ny_q, ny_d;
  logic                   drop_now_q, drop_now_d;
  logic [IdxW-1:0]        scan_idx_q, scan_idx_d;
  logic                   best_vld_q, best_vld_d;
  logic signed [ExtW-1:0] best_y_q, best_y_d;
  logic [IdxW-1:0]        best_idx_q, best_idx_d;
  logic                   grounded_q, grounded_d;
  logic [IdxW-1:0]        plt_idx_q, plt_idx_d;
  logic [POS_W-1:0]       snap_y_q, snap_y_d;
  logic                   done_q, done_d;
  logic                   land_q, land_d;
  logic                   dropping_q, dropping_d;
  logic [IdxW-1:0]        drop_slot_q, drop_slot_d;
  logic [CntW-1:0]        drop_cnt_q, drop_cnt_d;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.frame_tick) state_d = StScan;
      StScan:   if (last) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs; a tick seen outside StIdle is simply dropped
  always_comb begin
    start  = 1'b0;
    scan   = 1'b0;
    commit = 1'b0;
    unique case (state_q)
      StIdle:   start  = bus.frame_tick;
      StScan:   scan   = 1'b1;
      StCommit: commit = 1'b1;
      default:  ;
    endcase
  end

  assign last = (scan_idx_q == IdxW'(NUM_PLT - 1));

  // Candidate test for the slot under the scan pointer
  logic                   cur_en;
  logic signed [ExtW-1:0] px, py, pw;
  logic                   overlap, landing, hold, cand;

  always_comb begin
    cur_en = 1'b0;
    px     = '0;
    py     = '0;
    pw     = '0;
    for (int unsigned i = 0; i < NUM_PLT; i++) begin
      if (scan_idx_q == IdxW'(i)) begin
        cur_en = bus.plt_en[i];
        px     = sext(bus.plt_x[i*POS_W +: POS_W]);
        py     = sext(bus.plt_y[i*POS_W +: POS_W]);
        pw     = zext(bus.plt_w[i*POS_W +: POS_W]);
      end
    end
    overlap = (x_q + FootW >= px) && (x_q <= px + pw);
    landing = (y_q + FootH <= py) && (ny_q + FootH >= py);
    // Standing still (or pushed down) on the current support keeps it
    hold    = grounded_q && (scan_idx_q == plt_idx_q) && (y_q + FootH == py) && (ny_q >= y_q);
    cand    = cur_en && !(dropping_q && (scan_idx_q == drop_slot_q)) && overlap &&
              (landing || hold);
  end

  // Datapath next state
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    ny_d        = ny_q;
    drop_now_d  = drop_now_q;
    scan_idx_d  = scan_idx_q;
    best_vld_d  = best_vld_q;
    best_y_d    = best_y_q;
    best_idx_d  = best_idx_q;
    grounded_d  = grounded_q;
    plt_idx_d   = plt_idx_q;
    snap_y_d    = snap_y_q;
    done_d      = 1'b0;
    land_d      = 1'b0;
    dropping_d  = dropping_q;
    drop_slot_d = drop_slot_q;
    drop_cnt_d  = drop_cnt_q;

    if (start) begin
      x_d        = sext(bus.x_pos);
      y_d        = sext(bus.y_pos);
      ny_d       = sext(bus.next_y);
      best_vld_d = 1'b0;
      scan_idx_d = '0;
      // Drop only starts from a grounded, non-dropping state; it takes effect for this scan
      drop_now_d = bus.drop_req && grounded_q && !dropping_q;
      if (drop_now_d) begin
        dropping_d  = 1'b1;
        drop_slot_d = plt_idx_q;
        drop_cnt_d  = CntW'(DROP_FRAMES);
      end
    end

    if (scan) begin
      scan_idx_d = scan_idx_q + IdxW'(1);
      // Strict compare keeps the lower index on equal heights
      if (cand && (!best_vld_q || (py < best_y_q))) begin
        best_vld_d = 1'b1;
        best_y_d   = py;
        best_idx_d = scan_idx_q;
      end
    end

    if (commit) begin
      done_d = 1'b1;
      if (drop_now_q) begin
        grounded_d = 1'b0;
      end else begin
        if (dropping_q) begin
          drop_cnt_d = drop_cnt_q - CntW'(1);
          if (drop_cnt_q == CntW'(1)) dropping_d = 1'b0;
        end
        if (best_vld_q) begin
          grounded_d = 1'b1;
          plt_idx_d  = best_idx_q;
          snap_y_d   = POS_W'(best_y_q - FootH);
          land_d     = !grounded_q;
        end else begin
          grounded_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      ny_q        <= '0;
      drop_now_q  <= 1'b0;
      scan_idx_q  <= '0;
      best_vld_q  <= 1'b0;
      best_y_q    <= '0;
      best_idx_q  <= '0;
      grounded_q  <= 1'b0;
      plt_idx_q   <= '0;
      snap_y_q    <= '0;
      done_q      <= 1'b0;
      land_q      <= 1'b0;
      dropping_q  <= 1'b0;
      drop_slot_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      ny_q        <= ny_d;
      drop_now_q  <= drop_now_d;
      scan_idx_q  <= scan_idx_d;
      best_vld_q  <= best_vld_d;
      best_y_q    <= best_y_d;
      best_idx_q  <= best_idx_d;
      grounded_q  <= grounded_d;
      plt_idx_q   <= plt_idx_d;
      snap_y_q    <= snap_y_d;
      done_q      <= done_d;
      land_q      <= land_d;
      dropping_q  <= dropping_d;
      drop_slot_q <= drop_slot_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.busy       = scan | commit;
  assign bus.done       = done_q;
  assign bus.grounded   = grounded_q;
  assign bus.plt_idx    = plt_idx_q;
  assign bus.snap_y     = snap_y_q;
  assign bus.land_pulse = land_q;
  assign bus.dropping   = dropping_q;
endmodule

// File: tb/tb_plt_land_unit.sv
// Bench for plt_land_unit: directed frames with hand-computed expectations plus a frame-level
// model checked against the outputs on every falling edge.
module tb_plt_land_unit;
  localparam int NP  = 4;
  localparam int PW  = 11;
  localparam int FW  = 46;  // 23 * 2
  localparam int FH  = 60;  // 30 * 2
  localparam int LAT = NP + 1;
  localparam int DF  = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  plt_land_if #(.NUM_PLT(NP), .POS_W(PW)) bus ();

  plt_land_unit #(
    .NUM_PLT(NP), .POS_W(PW), .WIDTH(23), .HEIGHT(30), .SCALE(2), .DROP_FRAMES(DF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Stimulus held as plain integers, packed onto the bus
  int px[NP];
  int py[NP];
  int pw[NP];
  bit en[NP];
  int x, y, ny;
  bit ft, dreq;

  assign bus.frame_tick = ft;
  assign bus.drop_req   = dreq;
  assign bus.x_pos      = PW'(x);
  assign bus.y_pos      = PW'(y);
  assign bus.next_y     = PW'(ny);
  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign bus.plt_en[g]           = en[g];
    assign bus.plt_x[g*PW +: PW]   = PW'(px[g]);
    assign bus.plt_y[g*PW +: PW]   = PW'(py[g]);
    assign bus.plt_w[g*PW +: PW]   = PW'(pw[g]);
  end

  int checks = 0;
  int failures = 0;
  int nprint = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (nprint < 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
      nprint++;
    end
  endtask

  // ---------------- frame-level model ----------------
  bit e_busy, e_done, e_grounded, e_land, e_dropping;
  int e_idx, e_snap;
  int m_dleft, m_slot, m_wait, pend_win, pend_y;
  bit pend_drop;

  function automatic void model_reset();
    e_busy = 0; e_done = 0; e_grounded = 0; e_land = 0; e_dropping = 0;
    e_idx = 0; e_snap = 0; m_dleft = 0; m_slot = 0; m_wait = 0;
    pend_win = -1; pend_y = 0; pend_drop = 0;
  endfunction

  // Highest supporting platform for the latched frame, -1 if none
  function automatic void model_start();
    int best = -1;
    int by = 0;
    pend_drop = dreq && e_grounded && !e_dropping;
    if (pend_drop) begin
      e_dropping = 1;
      m_slot = e_idx;
      m_dleft = DF;
    end
    for (int i = 0; i < NP; i++) begin
      bit ok;
      if (!en[i]) continue;
      if (e_dropping && i == m_slot) continue;
      if (!(x + FW >= px[i] && x <= px[i] + pw[i])) continue;
      ok = (y + FH <= py[i] && ny + FH >= py[i]) ||
           (e_grounded && i == e_idx && y + FH == py[i] && ny >= y);
      if (ok && (best < 0 || py[i] < by)) begin
        best = i;
        by = py[i];
      end
    end
    pend_win = best;
    pend_y = by;
    e_busy = 1;
    m_wait = LAT;
  endfunction

  function automatic void model_commit();
    e_busy = 0;
    e_done = 1;
    e_land = 0;
    if (pend_drop) begin
      e_grounded = 0;
    end else begin
      if (e_dropping) begin
        m_dleft--;
        if (m_dleft == 0) e_dropping = 0;
      end
      if (pend_win >= 0) begin
        e_land = !e_grounded;
        e_grounded = 1;
        e_idx = pend_win;
        e_snap = pend_y - FH;
      end else begin
        e_grounded = 0;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) model_commit();
        else begin e_done = 0; e_land = 0; end
      end else begin
        e_done = 0;
        e_land = 0;
        if (ft) model_start();
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_busy",     int'(bus.busy),       int'(e_busy));
      chk("m_done",     int'(bus.done),       int'(e_done));
      chk("m_grounded", int'(bus.grounded),   int'(e_grounded));
      chk("m_plt_idx",  int'(bus.plt_idx),    e_idx);
      chk("m_snap_y",   int'($signed(bus.snap_y)), e_snap);
      chk("m_land",     int'(bus.land_pulse), int'(e_land));
      chk("m_dropping", int'(bus.dropping),   int'(e_dropping));
    end
  end

  int ndone = 0;
  initial forever begin
    @(negedge clk);
    if (bus.done) ndone++;
  end

  // ---------------- directed stimulus ----------------
  task automatic set_slot(input int i, input int sx, input int sy, input int sw, input bit se);
    px[i] = sx; py[i] = sy; pw[i] = sw; en[i] = se;
  endtask

  task automatic frame(input string name, input int fx, input int fy, input int fny,
                       input bit fd);
    int lat;
    x = fx; y = fy; ny = fny; dreq = fd;
    @(negedge clk); ft = 1;
    @(negedge clk); ft = 0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, LAT);
    dreq = 0;
  endtask

  task automatic chk_out(input string name, input int g, input int idx, input int snap,
                         input int land, input int drp);
    chk({name, "_grounded"}, int'(bus.grounded), g);
    chk({name, "_plt_idx"},  int'(bus.plt_idx), idx);
    chk({name, "_snap_y"},   int'($signed(bus.snap_y)), snap);
    chk({name, "_land"},     int'(bus.land_pulse), land);
    chk({name, "_dropping"}, int'(bus.dropping), drp);
  endtask

  initial begin
    int base;
    ft = 0; dreq = 0; x = 0; y = 0; ny = 0;
    for (int i = 0; i < NP; i++) set_slot(i, 0, 0, 0, 0);
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk_out("reset", 0, 0, 0, 0, 0);

    // Single landing on slot0
    set_slot(0, 420, 215, 105, 1);
    frame("land0", 430, 150, 160, 0);
    chk_out("land0", 1, 0, 155, 1, 0);

    // Standing still holds; walking off drops support without a land pulse
    frame("hold0", 430, 155, 155, 0);
    chk_out("hold0", 1, 0, 155, 0, 0);
    frame("walkoff", 600, 155, 155, 0);
    chk_out("walkoff", 0, 0, 155, 0, 0);

    // Two crossings: the higher platform wins
    set_slot(0, 420, 215, 105, 0);
    set_slot(1, 420, 300, 105, 1);
    set_slot(2, 420, 215, 105, 1);
    frame("higher", 430, 150, 260, 0);
    chk_out("higher", 1, 2, 155, 1, 0);
    frame("leave2", 600, 150, 150, 0);
    chk_out("leave2", 0, 2, 155, 0, 0);

    // Equal heights: lower index wins
    set_slot(2, 420, 215, 105, 0);
    set_slot(3, 420, 300, 105, 1);
    frame("tie", 430, 150, 260, 0);
    chk_out("tie", 1, 1, 240, 1, 0);

    // Drop-through of slot0 with slot1 below
    set_slot(0, 420, 215, 105, 1);
    set_slot(1, 420, 400, 105, 1);
    set_slot(3, 420, 300, 105, 0);
    frame("regain0", 430, 150, 160, 0);
    chk_out("regain0", 1, 0, 155, 0, 0);
    frame("drop", 430, 155, 158, 1);
    chk_out("drop", 0, 0, 155, 0, 1);
    for (int k = 1; k <= DF; k++) begin
      frame("window", 430, 150, 160, 0);
      chk("window_grounded", int'(bus.grounded), 0);
      chk("window_dropping", int'(bus.dropping), (k < DF) ? 1 : 0);
    end
    frame("reland", 430, 150, 160, 0);
    chk_out("reland", 1, 0, 155, 1, 0);
    frame("drop2", 430, 155, 158, 1);
    chk_out("drop2", 0, 0, 155, 0, 1);
    frame("catch", 430, 330, 345, 0);
    chk_out("catch", 1, 1, 340, 1, 1);
    // Drop request while already dropping is ignored
    frame("redrop", 430, 340, 340, 1);
    chk_out("redrop", 1, 1, 340, 0, 1);

    // Tick during a scan is ignored
    x = 600; y = 330; ny = 345;
    base = ndone;
    @(negedge clk); ft = 1;
    @(negedge clk); ft = 0;
    @(negedge clk); ft = 1;
    @(negedge clk); ft = 0;
    repeat (15) @(negedge clk);
    chk("busy_tick_dones", ndone - base, 1);
    chk("busy_tick_grounded", int'(bus.grounded), 0);

    // Reset in the middle of a scan
    frame("pre_rst", 430, 330, 345, 0);
    chk_out("pre_rst", 1, 1, 340, 1, 1);
    base = ndone;
    @(negedge clk); ft = 1;
    @(negedge clk); ft = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk_out("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 0;
    repeat (10) @(negedge clk);
    chk("rst_dones", ndone - base, 0);

    // Coordinate extremes
    set_slot(0, 900, 1000, 100, 1);
    for (int i = 1; i < NP; i++) set_slot(i, 0, 0, 0, 0);
    frame("far_left", -1000, -1000, 1023, 0);
    chk_out("far_left", 0, 0, 0, 0, 0);
    frame("deep_fall", 950, -1000, 1023, 0);
    chk_out("deep_fall", 1, 0, 940, 1, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
